// File: rtl/ahb_sram_arbiter.sv
// ahb_sram_arbiter: shares one AHB-Lite SRAM target between two AHB-Lite
// masters. Each master's address phase is parked in a hold register and the
// master is stalled on its own HREADY until the replayed NONSEQ single
// transfer finishes on the target side.
// Optional macro AHB_ARB_RR_EN: round-robin arbitration (default build is
// fixed priority with M0 winning every tie).
module ahb_sram_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          M0_HSEL,
   input  logic [AW-1:0] M0_HADDR,
   input  logic [1:0]    M0_HTRANS,
   input  logic          M0_HWRITE,
   input  logic [2:0]    M0_HSIZE,
   input  logic [2:0]    M0_HBURST,
   input  logic [DW-1:0] M0_HWDATA,
   output logic [DW-1:0] M0_HRDATA,
   output logic          M0_HREADY,
   output logic          M0_HRESP,
   input  logic          M1_HSEL,
   input  logic [AW-1:0] M1_HADDR,
   input  logic [1:0]    M1_HTRANS,
   input  logic          M1_HWRITE,
   input  logic [2:0]    M1_HSIZE,
   input  logic [2:0]    M1_HBURST,
   input  logic [DW-1:0] M1_HWDATA,
   output logic [DW-1:0] M1_HRDATA,
   output logic          M1_HREADY,
   output logic          M1_HRESP,
   output logic          S_HSEL,
   output logic [AW-1:0] S_HADDR,
   output logic [1:0]    S_HTRANS,
   output logic          S_HWRITE,
   output logic [2:0]    S_HSIZE,
   output logic [2:0]    S_HBURST,
   output logic [DW-1:0] S_HWDATA,
   input  logic [DW-1:0] S_HRDATA,
   input  logic          S_HREADYOUT,
   input  logic          S_HRESP
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [1:0]          pend_q, pend_d;
   logic                g_q, g_d;
   logic [1:0][AW-1:0]  haddr_q, haddr_d;
   logic [1:0]          hwrite_q, hwrite_d;
   logic [1:0][2:0]     hsize_q, hsize_d;
   logic [1:0][2:0]     hburst_q, hburst_d;

   logic [1:0]          m_hsel, m_nonseq, m_hwrite, m_hready, cap, done;
   logic [1:0][AW-1:0]  m_haddr;
   logic [1:0][2:0]     m_hsize, m_hburst;
   logic                in_addr, in_data, grant, win;
   logic                unused_ok;

   assign m_hsel   = {M1_HSEL, M0_HSEL};
   assign m_nonseq = {M1_HTRANS[1], M0_HTRANS[1]};
   assign m_hwrite = {M1_HWRITE, M0_HWRITE};
   assign m_haddr  = {M1_HADDR, M0_HADDR};
   assign m_hsize  = {M1_HSIZE, M0_HSIZE};
   assign m_hburst = {M1_HBURST, M0_HBURST};
   // HTRANS[0] only separates BUSY/SEQ from IDLE/NONSEQ; both pairs fold together here
   assign unused_ok = ^{M0_HTRANS[0], M1_HTRANS[0]};

   assign in_addr = (state_q == ST_ADDR);
   assign in_data = (state_q == ST_DATA);

   // owner's data phase finishing this cycle releases its stall
   assign done[0]  = in_data & ~g_q & S_HREADYOUT;
   assign done[1]  = in_data &  g_q & S_HREADYOUT;
   assign m_hready = ~pend_q | done;
   assign cap      = m_hsel & m_nonseq & m_hready;

`ifdef AHB_ARB_RR_EN
   logic last_q, last_d;

   // tie goes to the master not granted most recently
   always_comb begin
      if (&pend_d) win = ~last_q;
      else         win = pend_d[1];
      last_d = grant ? win : last_q;
   end

   // last-grant pointer starts at M1 so M0 takes the first tie
   always_ff @(posedge CLK) begin
      if (RESET) last_q <= 1'b1;
      else       last_q <= last_d;
   end
`else
   // fixed priority: M1 only wins when M0 has nothing pending
   always_comb win = ~pend_d[0];
`endif

   // pending flags and hold registers; a new capture beats a same-cycle clear
   always_comb begin
      pend_d   = (pend_q & ~done) | cap;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hburst_d = hburst_q;
      for (int i = 0; i < 2; i++) begin
         if (cap[i]) begin
            haddr_d[i]  = m_haddr[i];
            hwrite_d[i] = m_hwrite[i];
            hsize_d[i]  = m_hsize[i];
            hburst_d[i] = m_hburst[i];
         end
      end
   end

   // replay FSM; arbitrating on pend_d lets a fresh request start the next cycle
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      grant   = 1'b0;
      case (state_q)
         ST_IDLE: grant = |pend_d;
         ST_ADDR: state_d = ST_DATA;
         ST_DATA: begin
            if (S_HREADYOUT) begin
               grant   = |pend_d;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (grant) begin
         state_d = ST_ADDR;
         g_d     = win;
      end
   end

   // state registers; reset abandons any in-flight transfer
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         pend_q   <= '0;
         g_q      <= 1'b0;
         haddr_q  <= '0;
         hwrite_q <= '0;
         hsize_q  <= '0;
         hburst_q <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         g_q      <= g_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hburst_q <= hburst_d;
      end
   end

   assign S_HSEL   = in_addr;
   assign S_HTRANS = in_addr ? 2'b10 : 2'b00;
   assign S_HADDR  = in_addr ? haddr_q[g_q]  : '0;
   assign S_HWRITE = in_addr & hwrite_q[g_q];
   assign S_HSIZE  = in_addr ? hsize_q[g_q]  : '0;
   assign S_HBURST = in_addr ? hburst_q[g_q] : '0;
   assign S_HWDATA = in_data ? (g_q ? M1_HWDATA : M0_HWDATA) : '0;

   assign M0_HREADY = m_hready[0];
   assign M1_HREADY = m_hready[1];
   assign M0_HRESP  = in_data & ~g_q & S_HRESP;
   assign M1_HRESP  = in_data &  g_q & S_HRESP;
   assign M0_HRDATA = (in_data & ~g_q) ? S_HRDATA : '0;
   assign M1_HRDATA = (in_data &  g_q) ? S_HRDATA : '0;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// tb_ahb_sram_arbiter: directed bench with a small SRAM target model and a
// per-master scoreboard of expected read data / response.
module tb_ahb_sram_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        M0_HSEL, M1_HSEL;
   logic [31:0] M0_HADDR, M1_HADDR;
   logic [1:0]  M0_HTRANS, M1_HTRANS;
   logic        M0_HWRITE, M1_HWRITE;
   logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
   logic [31:0] M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
   logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
   logic        S_HSEL, S_HWRITE, S_HREADYOUT, S_HRESP;
   logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
   logic [1:0]  S_HTRANS;
   logic [2:0]  S_HSIZE, S_HBURST;

   typedef struct {
      logic        chk_rd;
      logic [31:0] rd;
      logic        resp;
   } sb_t;

   sb_t q0[$];
   sb_t q1[$];
   sb_t mon_e;
   int  n_vec = 0;
   int  n_err = 0;
   logic dp0 = 1'b0;
   logic dp1 = 1'b0;

   always #5 CLK = ~CLK;

   ahb_sram_arbiter #(.AW(32), .DW(32)) dut (
      .CLK(CLK), .RESET(RESET),
      .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS),
      .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST),
      .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY),
      .M0_HRESP(M0_HRESP),
      .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS),
      .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST),
      .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY),
      .M1_HRESP(M1_HRESP),
      .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS),
      .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
      .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT),
      .S_HRESP(S_HRESP)
   );

   // background contents of the target for words never written
   function automatic logic [31:0] pat(input int k);
      return 32'hA500_0000 | (32'(k) * 32'h0000_0111);
   endfunction

   // ---------------- SRAM target model ----------------
   logic [31:0] mem [16];
   logic [15:0] wr_flag = '0;
   logic        sl_act = 1'b0;
   logic        sl_wr = 1'b0;
   logic        sl_err = 1'b0;
   logic [3:0]  sl_idx = '0;
   int          sl_cnt = 0;
   int          ws_cfg = 0;
   logic        err_cfg = 1'b0;

   always @(posedge CLK) begin
      if (RESET) begin
         sl_act <= 1'b0;
         sl_cnt <= 0;
         sl_err <= 1'b0;
      end else begin
         if (sl_act && S_HREADYOUT) begin
            if (sl_wr) begin
               mem[sl_idx]     <= S_HWDATA;
               wr_flag[sl_idx] <= 1'b1;
            end
            sl_act <= 1'b0;
         end else if (sl_act && sl_cnt > 0) begin
            sl_cnt <= sl_cnt - 1;
         end
         if (S_HSEL && S_HTRANS[1] && S_HREADYOUT) begin
            sl_act <= 1'b1;
            sl_wr  <= S_HWRITE;
            sl_idx <= S_HADDR[5:2];
            sl_cnt <= ws_cfg + (err_cfg ? 1 : 0);
            sl_err <= err_cfg;
         end
      end
   end

   assign S_HREADYOUT = !sl_act || (sl_cnt == 0);
   assign S_HRESP     = sl_act && sl_err && (sl_cnt <= 1);
   assign S_HRDATA    = !sl_act ? 32'h0 :
                        (wr_flag[sl_idx] ? mem[sl_idx] : pat(int'(sl_idx)));

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
      if (m == 0) begin
         M0_HSEL = 1'b1; M0_HTRANS = 2'b10; M0_HADDR = a; M0_HWRITE = w;
         M0_HWDATA = d; M0_HSIZE = 3'd2; M0_HBURST = 3'd0;
      end else begin
         M1_HSEL = 1'b1; M1_HTRANS = 2'b10; M1_HADDR = a; M1_HWRITE = w;
         M1_HWDATA = d; M1_HSIZE = 3'd2; M1_HBURST = 3'd0;
      end
   endtask

   task automatic idle(input int m);
      if (m == 0) begin M0_HSEL = 1'b0; M0_HTRANS = 2'b00; end
      else        begin M1_HSEL = 1'b0; M1_HTRANS = 2'b00; end
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   // scoreboard monitor: pops a master's expectation when its data phase completes
   always @(negedge CLK) begin
      if (RESET) begin
         dp0 = 1'b0;
         dp1 = 1'b0;
      end else begin
         if (dp0 && M0_HREADY) begin
            chk("m0_sb_nonempty", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
               mon_e = q0.pop_front();
               if (mon_e.chk_rd) chk("m0_hrdata", M0_HRDATA, mon_e.rd);
               chk("m0_hresp", 32'(M0_HRESP), 32'(mon_e.resp));
            end
            dp0 = 1'b0;
         end
         if (M0_HSEL && M0_HTRANS[1] && M0_HREADY) dp0 = 1'b1;
         if (dp1 && M1_HREADY) begin
            chk("m1_sb_nonempty", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
               mon_e = q1.pop_front();
               if (mon_e.chk_rd) chk("m1_hrdata", M1_HRDATA, mon_e.rd);
               chk("m1_hresp", 32'(M1_HRESP), 32'(mon_e.resp));
            end
            dp1 = 1'b0;
         end
         if (M1_HSEL && M1_HTRANS[1] && M1_HREADY) dp1 = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int gord[$];
      int rem0, rem1, k0, k1;
      RESET = 1'b1;
      M0_HSEL = 0; M0_HADDR = 0; M0_HTRANS = 0; M0_HWRITE = 0; M0_HSIZE = 0; M0_HBURST = 0; M0_HWDATA = 0;
      M1_HSEL = 0; M1_HADDR = 0; M1_HTRANS = 0; M1_HWRITE = 0; M1_HSIZE = 0; M1_HBURST = 0; M1_HWDATA = 0;
      @(posedge CLK); @(posedge CLK);
      @(negedge CLK);
      chk("rst_m0_hready", 32'(M0_HREADY), 32'd1);
      chk("rst_m1_hready", 32'(M1_HREADY), 32'd1);
      chk("rst_m0_hresp",  32'(M0_HRESP), 32'd0);
      chk("rst_m1_hrdata", M1_HRDATA, 32'd0);
      chk("rst_s_hsel",    32'(S_HSEL), 32'd0);
      chk("rst_s_htrans",  32'(S_HTRANS), 32'd0);
      chk("rst_s_haddr",   S_HADDR, 32'd0);
      chk("rst_s_hwdata",  S_HWDATA, 32'd0);
      nxt();
      RESET = 1'b0;

      // single M0 write, zero-wait target
      issue(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF);
      q0.push_back('{1'b0, 32'h0, 1'b0});
      @(negedge CLK);
      chk("t1_m0_hready_t", 32'(M0_HREADY), 32'd1);
      chk("t1_s_htrans_t",  32'(S_HTRANS), 32'd0);
      nxt(); idle(0);
      @(negedge CLK);
      chk("t1_m0_hready_t1", 32'(M0_HREADY), 32'd0);
      chk("t1_s_htrans_t1",  32'(S_HTRANS), 32'h2);
      chk("t1_s_haddr_t1",   S_HADDR, 32'h8000_0010);
      chk("t1_s_hwrite_t1",  32'(S_HWRITE), 32'd1);
      nxt();
      @(negedge CLK);
      chk("t1_m0_hready_t2", 32'(M0_HREADY), 32'd1);
      chk("t1_s_hwdata_t2",  S_HWDATA, 32'hDEAD_BEEF);
      chk("t1_s_htrans_t2",  32'(S_HTRANS), 32'd0);
      nxt();
      issue(1, 32'h8000_0010, 1'b0, 32'h0);
      q1.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
      @(negedge CLK);
      chk("t1_s_hwdata_idle", S_HWDATA, 32'd0);
      nxt(); idle(1);
      repeat (3) nxt();

      // simultaneous reads, M0 served first
      issue(0, 32'h8000_0020, 1'b0, 32'h0);
      issue(1, 32'h8000_0024, 1'b0, 32'h0);
      q0.push_back('{1'b1, pat(8), 1'b0});
      q1.push_back('{1'b1, pat(9), 1'b0});
      nxt(); idle(0); idle(1);
      @(negedge CLK);
      chk("t2_m0_hready_1", 32'(M0_HREADY), 32'd0);
      chk("t2_m1_hready_1", 32'(M1_HREADY), 32'd0);
      chk("t2_s_haddr_1",   S_HADDR, 32'h8000_0020);
      nxt();
      @(negedge CLK);
      chk("t2_m0_hready_2", 32'(M0_HREADY), 32'd1);
      chk("t2_m1_hready_2", 32'(M1_HREADY), 32'd0);
      chk("t2_m1_hrdata_2", M1_HRDATA, 32'd0);
      nxt();
      @(negedge CLK);
      chk("t2_m1_hready_3", 32'(M1_HREADY), 32'd0);
      chk("t2_s_haddr_3",   S_HADDR, 32'h8000_0024);
      nxt();
      @(negedge CLK);
      chk("t2_m1_hready_4", 32'(M1_HREADY), 32'd1);
      chk("t2_m0_hrdata_4", M0_HRDATA, 32'd0);
      nxt(); nxt();

      // M1 read: 2 wait states then a 2-cycle ERROR; M0 queued behind it
      ws_cfg = 2; err_cfg = 1'b1;
      issue(1, 32'h8000_0030, 1'b0, 32'h0);
      q1.push_back('{1'b0, 32'h0, 1'b1});
      nxt(); idle(1);
      @(negedge CLK);
      chk("t4_m1_hready_1", 32'(M1_HREADY), 32'd0);
      nxt();
      issue(0, 32'h8000_0034, 1'b0, 32'h0);
      q0.push_back('{1'b1, pat(13), 1'b0});
      @(negedge CLK);
      chk("t4_m1_hready_2", 32'(M1_HREADY), 32'd0);
      chk("t4_m1_hresp_2",  32'(M1_HRESP), 32'd0);
      chk("t4_m0_hresp_2",  32'(M0_HRESP), 32'd0);
      nxt(); idle(0); ws_cfg = 0; err_cfg = 1'b0;
      @(negedge CLK);
      chk("t4_m1_hready_3", 32'(M1_HREADY), 32'd0);
      chk("t4_m1_hresp_3",  32'(M1_HRESP), 32'd0);
      nxt();
      @(negedge CLK);
      chk("t4_m1_hresp_err1",  32'(M1_HRESP), 32'd1);
      chk("t4_m1_hready_err1", 32'(M1_HREADY), 32'd0);
      chk("t4_m0_hresp_err1",  32'(M0_HRESP), 32'd0);
      nxt();
      @(negedge CLK);
      chk("t4_m1_hresp_err2",  32'(M1_HRESP), 32'd1);
      chk("t4_m1_hready_err2", 32'(M1_HREADY), 32'd1);
      chk("t4_m0_hresp_err2",  32'(M0_HRESP), 32'd0);
      chk("t4_m0_hready_err2", 32'(M0_HREADY), 32'd0);
      nxt();
      @(negedge CLK);
      chk("t4_s_haddr_m0", S_HADDR, 32'h8000_0034);
      nxt();
      @(negedge CLK);
      chk("t4_m0_hready_done", 32'(M0_HREADY), 32'd1);
      chk("t4_m0_hresp_done",  32'(M0_HRESP), 32'd0);
      nxt(); nxt();

      // M0 re-issues in its completion cycle while M1 is pending
      issue(0, 32'h8000_0004, 1'b0, 32'h0);
      q0.push_back('{1'b1, pat(1), 1'b0});
      nxt(); idle(0);
      issue(1, 32'h8000_0024, 1'b0, 32'h0);
      q1.push_back('{1'b1, pat(9), 1'b0});
      @(negedge CLK);
      chk("t5_m0_hready_1", 32'(M0_HREADY), 32'd0);
      nxt(); idle(1);
      issue(0, 32'h8000_0008, 1'b0, 32'h0);
      q0.push_back('{1'b1, pat(2), 1'b0});
      @(negedge CLK);
      chk("t5_m0_hready_cmpl", 32'(M0_HREADY), 32'd1);
      nxt(); idle(0);
      @(negedge CLK);
      chk("t5_m0_repend", 32'(M0_HREADY), 32'd0);
      chk("t5_s_htrans",  32'(S_HTRANS), 32'h2);
`ifdef AHB_ARB_RR_EN
      chk("t5_next_grant", S_HADDR, 32'h8000_0024);
`else
      chk("t5_next_grant", S_HADDR, 32'h8000_0008);
`endif
      repeat (5) nxt();

      // reset during a stalled data phase
      ws_cfg = 3;
      issue(0, 32'h8000_0000, 1'b0, 32'h0);
      issue(1, 32'h8000_0020, 1'b0, 32'h0);
      nxt(); idle(0); idle(1);
      nxt();
      RESET = 1'b1;
      @(negedge CLK);
      chk("t6_m0_stalled", 32'(M0_HREADY), 32'd0);
      chk("t6_s_hwdata_data", S_HWDATA, 32'd0);
      nxt();
      RESET = 1'b0; ws_cfg = 0;
      @(negedge CLK);
      chk("t6_m0_hready", 32'(M0_HREADY), 32'd1);
      chk("t6_m1_hready", 32'(M1_HREADY), 32'd1);
      chk("t6_s_htrans",  32'(S_HTRANS), 32'd0);
      chk("t6_s_hsel",    32'(S_HSEL), 32'd0);
      nxt();
      @(negedge CLK);
      chk("t6_s_htrans_after", 32'(S_HTRANS), 32'd0);
      chk("t6_m1_hready_after", 32'(M1_HREADY), 32'd1);
      nxt();

      // both masters stream 4 back-to-back reads each
      rem0 = 4; rem1 = 4; k0 = 0; k1 = 0;
      for (int c = 0; c < 60 && gord.size() < 8; c++) begin
         if (M0_HREADY) begin
            if (rem0 > 0) begin
               issue(0, 32'h8000_0000 + 32'(k0 * 4), 1'b0, 32'h0);
               q0.push_back('{1'b1, pat(k0), 1'b0});
               k0++; rem0--;
            end else idle(0);
         end
         if (M1_HREADY) begin
            if (rem1 > 0) begin
               issue(1, 32'h8000_1020 + 32'(k1 * 4), 1'b0, 32'h0);
               q1.push_back('{1'b1, pat(8 + k1), 1'b0});
               k1++; rem1--;
            end else idle(1);
         end
         @(negedge CLK);
         if (S_HTRANS == 2'b10) gord.push_back(int'(S_HADDR[12]));
         nxt();
      end
      idle(0); idle(1);
      chk("bb_grant_count", 32'(gord.size()), 32'd8);
      for (int i = 0; i < gord.size(); i++) begin
`ifdef AHB_ARB_RR_EN
         chk($sformatf("bb_grant_%0d", i), 32'(gord[i]), 32'(i % 2));
`else
         chk($sformatf("bb_grant_%0d", i), 32'(gord[i]), (i < 4) ? 32'd0 : 32'd1);
`endif
      end
      repeat (4) nxt();

      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
